// File: rtl/traffic_master_gen.sv
// rtl/traffic_master_gen.sv - seeded LFSR traffic-generating master for one crossbar master port
//
// Issues read/write requests using a free-running 32-bit Galois LFSR as the
// randomness source. Four traffic modes are available, and an optional bounded
// transaction count stops the run. Random idle gaps separate requests. In the
// write-then-readback mode the master checks the data it reads back. An ack
// timeout monitor flags a request that is never accepted.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   enable                   start/continue generation (sampled in IDLE)
//   mode[1:0]                0 random, 1 sequential write, 2 write+readback, 3 random read
//   num_txn[15:0]            transactions per run, 0 = unlimited
//   req/addr/cmd/wdata       request to slave (addr/cmd/wdata are 0 while req=0)
//   ack                      slave accepted the request
//   resp/rdata               read data valid
//   busy                     FSM not in IDLE
//   done                     run complete, held until enable drops
//   txn_cnt[15:0]            completed transactions
//   err_cnt[15:0]            saturating read-back mismatch count
//   timeout_err              sticky ack-timeout flag

module traffic_master_gen #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          SEL_W   = 2,
  parameter int          OFFS_W  = 8,
  parameter int          GAP_W   = 3,
  parameter logic [31:0] SEED    = 32'h1,
  parameter int          TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [15:0]       num_txn,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic              cmd,
  output logic [DATA_W-1:0] wdata,
  input  logic              ack,
  input  logic              resp,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       txn_cnt,
  output logic [15:0]       err_cnt,
  output logic              timeout_err
);

  localparam int              SO_W      = SEL_W + OFFS_W;
  localparam int              TMO_W     = $clog2(TIMEOUT + 2);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT);
  localparam logic [31:0]     SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0]     LFSR_TAPS = 32'h8020_0003;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       num_q, num_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cmd_q, cmd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [15:0]       txn_q, txn_d;
  logic [15:0]       err_q, err_d;
  logic              tmo_err_q, tmo_err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [SO_W-1:0]   seq_q, seq_d;
  logic [SO_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  // set when a run completes: the next start clears txn_cnt and the sequential address
  logic              fresh_q, fresh_d;

  logic [SO_W-1:0]   rnd_so;
  logic [DATA_W-1:0] lfsr_w;
  logic [DATA_W-1:0] seq_w;
  logic [SO_W-1:0]   b_so;
  logic              b_cmd;
  logic [DATA_W-1:0] b_wd;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [SO_W-1:0] so);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[ADDR_W-1 -: SEL_W] = so[SO_W-1 -: SEL_W];
    a[OFFS_W-1:0]        = so[OFFS_W-1:0];
    return a;
  endfunction

  assign rnd_so = {lfsr_q[31 -: SEL_W], lfsr_q[OFFS_W-1:0]};

  // zero-extend or truncate the LFSR word and the sequence index to DATA_W
  always_comb begin
    lfsr_w = '0;
    seq_w  = '0;
    for (int i = 0; i < DATA_W && i < 32; i++) lfsr_w[i] = lfsr_q[i];
    for (int i = 0; i < DATA_W && i < SO_W; i++) seq_w[i] = seq_q[i];
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    gap_d     = gap_q;
    mode_d    = mode_q;
    num_d     = num_q;
    req_d     = req_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    txn_d     = txn_q;
    err_d     = err_q;
    tmo_err_d = tmo_err_q;
    tmo_d     = tmo_q;
    seq_d     = seq_q;
    hold_d    = hold_q;
    exp_d     = exp_q;
    fresh_d   = fresh_q;
    b_so      = rnd_so;
    b_cmd     = lfsr_q[16];
    b_wd      = lfsr_q[16] ? lfsr_w : '0;

    case (state_q)
      S_IDLE: begin
        if (!enable) begin
          done_d = 1'b0;
        end else if (!done_q) begin
          state_d = S_GAP;
          gap_d   = lfsr_q[GAP_W-1:0];
          mode_d  = mode;
          num_d   = num_txn;
          if (fresh_q) begin
            txn_d   = '0;
            seq_d   = '0;
            fresh_d = 1'b0;
          end
        end
      end

      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          case (mode_q)
            2'd1: begin
              b_so  = seq_q;
              b_cmd = 1'b1;
              b_wd  = seq_w;
              seq_d = seq_q + 1'b1;
            end
            2'd2: begin
              // odd transactions read back the address written by the even one before
              if (txn_q[0]) begin
                b_so  = hold_q;
                b_cmd = 1'b0;
                b_wd  = '0;
              end else begin
                b_cmd  = 1'b1;
                b_wd   = lfsr_w;
                hold_d = rnd_so;
                exp_d  = lfsr_w;
              end
            end
            2'd3: begin
              b_cmd = 1'b0;
              b_wd  = '0;
            end
            default: ;
          endcase
          state_d = S_REQ;
          req_d   = 1'b1;
          tmo_d   = '0;
          addr_d  = mk_addr(b_so);
          cmd_d   = b_cmd;
          wdata_d = b_wd;
        end
      end

      S_REQ: begin
        if (ack) begin
          req_d   = 1'b0;
          addr_d  = '0;
          cmd_d   = 1'b0;
          wdata_d = '0;
          state_d = cmd_q ? S_NEXT : S_RESP;
        end else if (tmo_q != TMO_LIM) begin
          // no abort exists, so the request keeps waiting after the flag is raised
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_LIM) tmo_err_d = 1'b1;
        end
      end

      S_RESP: begin
        if (resp) begin
          if (mode_q == 2'd2 && txn_q[0] && rdata != exp_q && err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        txn_d = txn_q + 16'd1;
        if (num_q != 16'd0 && txn_q + 16'd1 == num_q) begin
          done_d  = 1'b1;
          fresh_d = 1'b1;
          state_d = S_IDLE;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          gap_d   = lfsr_q[GAP_W-1:0];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED_EFF;
      gap_q     <= '0;
      mode_q    <= '0;
      num_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      cmd_q     <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      txn_q     <= '0;
      err_q     <= '0;
      tmo_err_q <= 1'b0;
      tmo_q     <= '0;
      seq_q     <= '0;
      hold_q    <= '0;
      exp_q     <= '0;
      fresh_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      gap_q     <= gap_d;
      mode_q    <= mode_d;
      num_q     <= num_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      txn_q     <= txn_d;
      err_q     <= err_d;
      tmo_err_q <= tmo_err_d;
      tmo_q     <= tmo_d;
      seq_q     <= seq_d;
      hold_q    <= hold_d;
      exp_q     <= exp_d;
      fresh_q   <= fresh_d;
    end
  end

  assign req         = req_q;
  assign addr        = addr_q;
  assign cmd         = cmd_q;
  assign wdata       = wdata_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign txn_cnt     = txn_q;
  assign err_cnt     = err_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_traffic_master_gen.sv
// tb/tb_traffic_master_gen.sv - directed self-checking bench for traffic_master_gen

module tb_traffic_master_gen;

  typedef struct packed {
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic [31:0] l;
  } ent_t;

  logic clk;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // instance A: SEED=ACE1, bench-driven slave
  logic        a_enable, a_req, a_cmd, a_ack, a_resp, a_busy, a_done, a_tmo;
  logic [1:0]  a_mode;
  logic [15:0] a_num, a_txn, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  // instances B (SEED=0) and C (SEED=1): shared inputs, slave acks immediately
  logic        bc_enable;
  logic [1:0]  bc_mode;
  logic [15:0] bc_num;
  logic        b_req, b_cmd, b_busy, b_done, b_tmo;
  logic [15:0] b_txn, b_err;
  logic [31:0] b_addr, b_wdata;
  logic        c_req, c_cmd, c_busy, c_done, c_tmo;
  logic [15:0] c_txn, c_err;
  logic [31:0] c_addr, c_wdata;
  // instance D: SEL_W=1, OFFS_W=2, 8-bit address/data
  logic        d_enable, d_req, d_cmd, d_busy, d_done, d_tmo;
  logic [1:0]  d_mode;
  logic [15:0] d_num, d_txn, d_err;
  logic [7:0]  d_addr, d_wdata;

  // slave model state
  logic        ack_en, corrupt, pend;
  logic [31:0] st_addr, st_data, pend_addr;
  logic        a_req_l, b_req_l, c_req_l, d_req_l;
  ent_t        a_log[$], b_log[$], c_log[$], d_log[$];

  // reference LFSRs; *_prev holds the value the DUT used on the last edge
  logic [31:0] m_a, m_a_prev, m_1, m_1_prev;

  traffic_master_gen #(.SEED(32'hACE1)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(a_enable), .mode(a_mode), .num_txn(a_num),
    .req(a_req), .addr(a_addr), .cmd(a_cmd), .wdata(a_wdata), .ack(a_ack), .resp(a_resp),
    .rdata(a_rdata), .busy(a_busy), .done(a_done), .txn_cnt(a_txn), .err_cnt(a_err),
    .timeout_err(a_tmo));

  traffic_master_gen #(.SEED(32'h0)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(bc_enable), .mode(bc_mode), .num_txn(bc_num),
    .req(b_req), .addr(b_addr), .cmd(b_cmd), .wdata(b_wdata), .ack(b_req), .resp(1'b1),
    .rdata(32'h0), .busy(b_busy), .done(b_done), .txn_cnt(b_txn), .err_cnt(b_err),
    .timeout_err(b_tmo));

  traffic_master_gen #(.SEED(32'h1)) u_c (
    .clk(clk), .reset_n(reset_n), .enable(bc_enable), .mode(bc_mode), .num_txn(bc_num),
    .req(c_req), .addr(c_addr), .cmd(c_cmd), .wdata(c_wdata), .ack(c_req), .resp(1'b1),
    .rdata(32'h0), .busy(c_busy), .done(c_done), .txn_cnt(c_txn), .err_cnt(c_err),
    .timeout_err(c_tmo));

  traffic_master_gen #(.ADDR_W(8), .DATA_W(8), .SEL_W(1), .OFFS_W(2)) u_d (
    .clk(clk), .reset_n(reset_n), .enable(d_enable), .mode(d_mode), .num_txn(d_num),
    .req(d_req), .addr(d_addr), .cmd(d_cmd), .wdata(d_wdata), .ack(d_req), .resp(1'b0),
    .rdata(8'h0), .busy(d_busy), .done(d_done), .txn_cnt(d_txn), .err_cnt(d_err),
    .timeout_err(d_tmo));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] lstep(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  function automatic logic [31:0] m0_addr(input logic [31:0] l);
    return {l[31:30], 22'd0, l[7:0]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_a <= 32'hACE1; m_a_prev <= 32'hACE1;
      m_1 <= 32'h1;    m_1_prev <= 32'h1;
    end else begin
      m_a <= lstep(m_a); m_a_prev <= m_a;
      m_1 <= lstep(m_1); m_1_prev <= m_1;
    end
  end

  // slave for A and request logging, all updated mid-cycle
  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 1'b0; a_ack = 1'b0; a_resp = 1'b0; a_rdata = '0;
    end else begin
      a_resp  = 1'b0;
      a_rdata = '0;
      if (pend) begin
        a_resp  = 1'b1;
        a_rdata = (pend_addr == st_addr) ? (st_data ^ {31'd0, corrupt}) : 32'hDEAD_BEEF;
        pend    = 1'b0;
      end
      a_ack = a_req && ack_en;
      if (a_req && ack_en) begin
        if (a_cmd) begin
          st_addr = a_addr; st_data = a_wdata;
        end else begin
          pend = 1'b1; pend_addr = a_addr;
        end
      end
    end
    if (a_req && !a_req_l) a_log.push_back({a_addr, a_cmd, a_wdata, m_a_prev});
    if (b_req && !b_req_l) b_log.push_back({b_addr, b_cmd, b_wdata, m_1_prev});
    if (c_req && !c_req_l) c_log.push_back({c_addr, c_cmd, c_wdata, m_1_prev});
    if (d_req && !d_req_l) d_log.push_back({24'd0, d_addr, d_cmd, 24'd0, d_wdata, 32'd0});
    a_req_l = a_req; b_req_l = b_req; c_req_l = c_req; d_req_l = d_req;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; a_enable = 1'b0; bc_enable = 1'b0; d_enable = 1'b0;
    tick(2);
    reset_n = 1'b1;
    a_log.delete(); b_log.delete(); c_log.delete(); d_log.delete();
  endtask

  task automatic wait_a_done(input string tag, input int budget);
    for (int i = 0; i < budget && a_done !== 1'b1; i++) tick(1);
    check(tag, a_done, 1);
  endtask

  task automatic check_m0_log(input string tag, input int n, input logic sel);
    ent_t e;
    check({tag, "_len"}, sel ? b_log.size() : a_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < (sel ? b_log.size() : a_log.size())) begin
        e = sel ? b_log[i] : a_log[i];
        check($sformatf("%s%0d_addr", tag, i), e.addr, m0_addr(e.l));
        check($sformatf("%s%0d_cmd", tag, i), e.cmd, e.l[16]);
        check($sformatf("%s%0d_wdata", tag, i), e.wdata, e.l[16] ? e.l : 32'h0);
      end
    end
  endtask

  logic [31:0] first_addr, first_wd;
  logic        first_cmd;
  int          g;

  initial begin
    reset_n = 1'b0; a_enable = 0; a_mode = 0; a_num = 0; bc_enable = 0; bc_mode = 0; bc_num = 0;
    d_enable = 0; d_mode = 0; d_num = 0; ack_en = 0; corrupt = 0;
    a_req_l = 0; b_req_l = 0; c_req_l = 0; d_req_l = 0;
    st_addr = '0; st_data = '0; pend_addr = '0;
    tick(2);
    check("rst_req", a_req, 0);      check("rst_addr", a_addr, 0);
    check("rst_cmd", a_cmd, 0);      check("rst_wdata", a_wdata, 0);
    check("rst_busy", a_busy, 0);    check("rst_done", a_done, 0);
    check("rst_txn", a_txn, 0);      check("rst_err", a_err, 0);
    check("rst_tmo", a_tmo, 0);
    reset_n = 1'b1;

    // mode 1, four writes, ack tied high; enable-to-req latency is 2+gap
    a_mode = 2'd1; a_num = 16'd4; ack_en = 1'b1;
    g = int'(m_a[2:0]);
    a_enable = 1'b1;
    tick(1 + g);
    check("lat_pre", a_req, 0);
    tick(1);
    check("lat_req", a_req, 1);
    check("lat_busy", a_busy, 1);
    wait_a_done("m1_done", 200);
    check("m1_len", a_log.size(), 4);
    for (int i = 0; i < 4 && i < a_log.size(); i++) begin
      check($sformatf("m1_addr%0d", i), a_log[i].addr, i);
      check($sformatf("m1_cmd%0d", i), a_log[i].cmd, 1);
      check($sformatf("m1_wdata%0d", i), a_log[i].wdata, i);
    end
    check("m1_txn", a_txn, 4);
    check("m1_busy", a_busy, 0);
    check("m1_req_idle", a_req, 0);
    a_enable = 1'b0;
    tick(1);
    check("m1_done_clr", a_done, 0);
    check("m1_txn_hold", a_txn, 4);

    // mode 2, echoing slave then corrupting slave
    a_log.delete();
    a_mode = 2'd2; a_num = 16'd2; a_enable = 1'b1;
    wait_a_done("m2_done", 200);
    check("m2_txn", a_txn, 2);
    check("m2_err_ok", a_err, 0);
    check("m2_len", a_log.size(), 2);
    if (a_log.size() == 2) begin
      check("m2_waddr", a_log[0].addr, m0_addr(a_log[0].l));
      check("m2_wcmd", a_log[0].cmd, 1);
      check("m2_wdata", a_log[0].wdata, a_log[0].l);
      check("m2_raddr", a_log[1].addr, m0_addr(a_log[0].l));
      check("m2_rcmd", a_log[1].cmd, 0);
    end
    a_enable = 1'b0;
    tick(1);
    corrupt = 1'b1;
    a_enable = 1'b1;
    wait_a_done("m2c_done", 200);
    check("m2c_err", a_err, 1);
    a_enable = 1'b0;
    corrupt = 1'b0;

    // mode 0 from reset on A, B (SEED 0), C (SEED 1); D wraps its address
    do_reset();
    a_mode = 2'd0; a_num = 16'd6; a_enable = 1'b1;
    bc_mode = 2'd0; bc_num = 16'd5; bc_enable = 1'b1;
    d_mode = 2'd1; d_num = 16'd9; d_enable = 1'b1;
    for (int i = 0; i < 600 && !(a_done && b_done && c_done && d_done); i++) tick(1);
    check("run1_a_done", a_done, 1);
    check("b_done", b_done, 1);
    check("c_done", c_done, 1);
    check("d_done", d_done, 1);
    check_m0_log("a_run1_", 6, 1'b0);
    check_m0_log("b_", 5, 1'b1);
    check("c_len", c_log.size(), 5);
    for (int i = 0; i < 5 && i < c_log.size(); i++) begin
      check($sformatf("c%0d_addr", i), c_log[i].addr, m0_addr(c_log[i].l));
      check($sformatf("c%0d_wdata", i), c_log[i].wdata, c_log[i].l[16] ? c_log[i].l : 32'h0);
    end
    check("d_len", d_log.size(), 9);
    for (int i = 0; i < 9 && i < d_log.size(); i++) begin
      check($sformatf("d_addr%0d", i), d_log[i].addr, (((i % 8) >> 2) << 7) | ((i % 8) & 3));
      check($sformatf("d_wdata%0d", i), d_log[i].wdata, i % 8);
    end
    check("d_txn", d_txn, 9);

    // same mode-0 run again from reset
    do_reset();
    a_enable = 1'b1;
    wait_a_done("run2_a_done", 300);
    check_m0_log("a_run2_", 6, 1'b0);
    if (a_log.size() > 0) begin
      first_addr = m0_addr(a_log[0].l);
      first_cmd  = a_log[0].l[16];
      first_wd   = a_log[0].l[16] ? a_log[0].l : 32'h0;
    end

    // asynchronous reset while a request is waiting for ack
    do_reset();
    a_mode = 2'd1; a_num = 16'd0; ack_en = 1'b1; a_enable = 1'b1;
    for (int i = 0; i < 200 && a_txn < 16'd3; i++) tick(1);
    check("mid_txn_reach", a_txn, 3);
    ack_en = 1'b0;
    for (int i = 0; i < 20 && a_req !== 1'b1; i++) tick(1);
    check("mid_req", a_req, 1);
    check("mid_addr", a_addr, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_req", a_req, 0);
    check("ar_addr", a_addr, 0);
    check("ar_txn", a_txn, 0);
    check("ar_busy", a_busy, 0);
    a_enable = 1'b0;
    tick(1);
    reset_n = 1'b1;
    a_log.delete();
    a_mode = 2'd0; a_num = 16'd1; ack_en = 1'b1; a_enable = 1'b1;
    wait_a_done("rs_done", 100);
    check("rs_len", a_log.size(), 1);
    if (a_log.size() > 0) begin
      check("rs_addr", a_log[0].addr, first_addr);
      check("rs_cmd", a_log[0].cmd, first_cmd);
      check("rs_wdata", a_log[0].wdata, first_wd);
    end

    // ack withheld for 300 cycles
    do_reset();
    a_mode = 2'd1; a_num = 16'd1; ack_en = 1'b0; a_enable = 1'b1;
    for (int i = 0; i < 20 && a_req !== 1'b1; i++) tick(1);
    check("to_req", a_req, 1);
    tick(254);
    check("to_254", a_tmo, 0);
    tick(1);
    check("to_255", a_tmo, 1);
    check("to_req_held", a_req, 1);
    tick(44);
    check("to_299_req", a_req, 1);
    ack_en = 1'b1;
    tick(1);
    check("to_ack_req", a_req, 0);
    wait_a_done("to_done", 50);
    check("to_txn", a_txn, 1);
    check("to_sticky", a_tmo, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
